// File: rtl/l2_fifo_spi_tx_pkg.sv
// Shared types and constants for the L2 FIFO SPI transmitter.
package l2_tx_pkg;

  localparam int L2_TX_DW    = 32;
  localparam int L2_TX_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SHIFT,
    GAP
  } l2_tx_state_e;

endpackage

// File: rtl/l2_fifo_spi_tx_if.sv
// FIFO read port plus SPI pins of the L2 FIFO SPI transmitter.
interface l2_fifo_spi_tx_if
  import l2_tx_pkg::*;
#(
  parameter int DW = L2_TX_DW
) ();

  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd;
  logic          sclk;
  logic          mosi;
  logic          cs_n;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd,
    output sclk,
    output mosi,
    output cs_n
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd,
    input  sclk,
    input  mosi,
    input  cs_n
  );

endinterface

// File: rtl/l2_fifo_spi_tx_clkgen.sv
// sclk divider: toggles sclk every CLK_DIV cycles while running, strobes on each edge.
module l2_tx_clkgen
  import l2_tx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DCW-1:0] r_div_cnt;
  logic           r_sclk;
  logic           w_tc;

  assign w_tc   = i_run && (r_div_cnt == DCW'(CLK_DIV - 1));
  assign o_rise = w_tc && !r_sclk;
  assign o_fall = w_tc && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (i_clear) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (i_run) begin
      if (w_tc) begin
        r_div_cnt <= '0;
        r_sclk    <= ~r_sclk;
      end else begin
        r_div_cnt <= r_div_cnt + DCW'(1);
      end
    end
  end

endmodule

// File: rtl/l2_fifo_spi_tx.sv
// SPI mode-0 master draining the L2 FIFO, one word per cs_n frame, MSB first.
// Define L2_TX_BURST_EN to chain back-to-back words inside a single cs_n frame.
module l2_fifo_spi_tx
  import l2_tx_pkg::*;
#(
  parameter int DW      = L2_TX_DW,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_clr,
  l2_fifo_spi_tx_if.master       bus,
  output logic                   o_busy,
  output logic                   o_word_done,
  output logic [L2_TX_CNT_W-1:0] o_tx_cnt
);

  localparam int BCW = $clog2(DW);
  localparam int GCW = $clog2(CS_GAP + 1);

  l2_tx_state_e           r_state;
  l2_tx_state_e           w_state_next;
  logic [DW-2:0]          r_shreg;
  logic [BCW-1:0]         r_bit_cnt;
  logic [GCW-1:0]         r_gap_cnt;
  logic                   r_mosi;
  logic                   r_cs_n;
  logic                   r_word_done;
  logic [L2_TX_CNT_W-1:0] r_tx_cnt;
  logic                   w_sclk;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_last;
  logic                   w_end;
  logic                   w_burst;
  logic                   w_fifo_rd;
  logic                   w_busy;

  l2_tx_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .i_run   (r_state == SHIFT),
    .i_clear (i_clr || (r_state != SHIFT)),
    .o_sclk  (w_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_last = (r_bit_cnt == BCW'(DW - 1));
  assign w_end  = (r_state == SHIFT) && w_fall && w_last;

`ifdef L2_TX_BURST_EN
  assign w_burst = i_enable && !bus.fifo_empty;
`else
  assign w_burst = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_clr) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_enable && !bus.fifo_empty) w_state_next = POP;
        POP:     w_state_next = LOAD;
        LOAD:    w_state_next = SHIFT;
        SHIFT:   if (w_end) w_state_next = w_burst ? POP : GAP;
        GAP:     if (r_gap_cnt == GCW'(CS_GAP - 1)) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_fifo_rd = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      IDLE:    w_busy    = 1'b0;
      POP:     w_fifo_rd = 1'b1;
      default: w_busy    = 1'b1;
    endcase
  end

  // The rise strobe needs no action: data is simply held across the high phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_word_done <= 1'b0;
      r_tx_cnt    <= '0;
    end else if (i_clr) begin
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= w_end;
      case (r_state)
        LOAD: begin
          r_shreg   <= bus.fifo_dout[DW-2:0];
          r_mosi    <= bus.fifo_dout[DW-1];
          r_cs_n    <= 1'b0;
          r_bit_cnt <= '0;
        end
        SHIFT: begin
          if (w_fall) begin
            if (!w_last) begin
              r_mosi    <= r_shreg[DW-2];
              r_shreg   <= r_shreg << 1;
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end else begin
              r_tx_cnt  <= r_tx_cnt + L2_TX_CNT_W'(1);
              r_gap_cnt <= '0;
              if (!w_burst) r_cs_n <= 1'b1;
            end
          end
        end
        GAP:     r_gap_cnt <= r_gap_cnt + GCW'(1);
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd = w_fifo_rd;
  assign bus.sclk    = w_sclk;
  assign bus.mosi    = r_mosi;
  assign bus.cs_n    = r_cs_n;
  assign o_busy      = w_busy;
  assign o_word_done = r_word_done;
  assign o_tx_cnt    = r_tx_cnt;

  logic w_unused;
  assign w_unused = w_rise;

endmodule

// File: tb/tb_l2_fifo_spi_tx.sv
// Self-checking bench for l2_fifo_spi_tx: FIFO model, mosi capture scoreboard, scenario tasks.
module tb_l2_fifo_spi_tx;
  import l2_tx_pkg::*;

  localparam int DW      = 32;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;
  localparam int FRAME   = 2 + 2 * DW * CLK_DIV;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        enable = 1'b0;
  logic        clr    = 1'b0;
  logic        busy;
  logic        word_done;
  logic [15:0] tx_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  l2_fifo_spi_tx_if #(.DW(DW)) bus ();

  l2_fifo_spi_tx #(
    .DW      (DW),
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (enable),
    .i_clr       (clr),
    .bus         (bus),
    .o_busy      (busy),
    .o_word_done (word_done),
    .o_tx_cnt    (tx_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: dout one cycle after the pop strobe, empty flag refreshed every edge.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          fifo_empty_r = 1'b1;
  logic [DW-1:0] dout_r       = '0;
  int            underflow    = 0;
  int            rd_total     = 0;
  int            last_pop_cyc = 0;
  int            cyc          = 0;

  assign bus.fifo_empty = fifo_empty_r;
  assign bus.fifo_dout  = dout_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd) begin
      rd_total     <= rd_total + 1;
      last_pop_cyc <= cyc;
      if (fifo_q.size() == 0) underflow <= underflow + 1;
      else dout_r <= fifo_q.pop_front();
    end
    fifo_empty_r <= (fifo_q.size() == 0);
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Scoreboard: capture mosi on each rising sclk, compare against the queued word at word_done.
  initial begin : monitor
    logic          prev_sclk;
    logic          prev_mosi;
    logic [DW-1:0] cap;
    logic [DW-1:0] expw;
    int            mrise;
    bit            unstable;
    prev_sclk = 1'b0; prev_mosi = 1'b0; cap = '0; mrise = 0; unstable = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sclk && !prev_sclk && !bus.cs_n) begin
        cap   = {cap[DW-2:0], bus.mosi};
        mrise = mrise + 1;
      end
      if (bus.sclk && prev_sclk && (bus.mosi !== prev_mosi)) unstable = 1'b1;
      if (word_done) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL word_data: got %h with no word expected", cap);
        end else begin
          expw = exp_q.pop_front();
          if (cap !== expw) $display("FAIL word_data: got %h expected %h", cap, expw);
          else begin n_pass++; $display("word %h ok", cap); end
        end
        n_chk++;
        if (mrise !== DW) $display("FAIL rise_count: got %0d expected %0d", mrise, DW);
        else n_pass++;
        n_chk++;
        if (unstable !== 1'b0) $display("FAIL mosi_stable: got changing mosi while sclk high, expected stable");
        else n_pass++;
      end
      if (word_done || bus.cs_n) begin
        cap = '0; mrise = 0; unstable = 1'b0;
      end
      prev_sclk = bus.sclk;
      prev_mosi = bus.mosi;
    end
  end

  task automatic wait_wd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (word_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int n, output int got);
    logic last;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.cs_n) break;
    end
    last = bus.sclk;
    for (int i = 0; i < 4 * n * CLK_DIV + 20; i++) begin
      @(negedge clk);
      if (bus.sclk && !last) got++;
      last = bus.sclk;
      if (got == n) break;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.fifo_rd, bus.sclk, bus.mosi, bus.cs_n, busy, word_done} !== 6'b000100)
      $display("FAIL reset_outputs: got %b expected 000100",
               {bus.fifo_rd, bus.sclk, bus.mosi, bus.cs_n, busy, word_done});
    else n_pass++;
    n_chk++;
    if (tx_cnt !== 16'd0) $display("FAIL reset_tx_cnt: got %0d expected 0", tx_cnt);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
    else n_pass++;
    $display("reset done");
  endtask

  task automatic test_empty;
    int rd0, cs_low, bsy;
    rd0 = rd_total; cs_low = 0; bsy = 0;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.cs_n) cs_low++;
      if (busy) bsy++;
    end
    n_chk++;
    if (rd_total - rd0 !== 0) $display("FAIL empty_no_pop: got %0d pops expected 0", rd_total - rd0);
    else n_pass++;
    n_chk++;
    if (cs_low !== 0) $display("FAIL empty_cs_n: got %0d low cycles expected 0", cs_low);
    else n_pass++;
    n_chk++;
    if (bsy !== 0) $display("FAIL empty_busy: got %0d busy cycles expected 0", bsy);
    else n_pass++;
    $display("empty fifo idle for 100 cycles");
  endtask

  task automatic test_single;
    bit ok;
    int rd0, g;
    bit cs_ok;
    rd0 = rd_total;
    push_word(32'hA5C3_0F81);
    wait_wd(FRAME + 50, ok);
    n_chk++;
    if (!ok) $display("FAIL single_timeout: got no word_done expected one within %0d", FRAME + 50);
    else n_pass++;
    n_chk++;
    if (rd_total - rd0 !== 1) $display("FAIL single_pops: got %0d expected 1", rd_total - rd0);
    else n_pass++;
    n_chk++;
    if (cyc - last_pop_cyc !== FRAME)
      $display("FAIL frame_len: got %0d expected %0d", cyc - last_pop_cyc, FRAME);
    else n_pass++;
    n_chk++;
    if (tx_cnt !== 16'd1) $display("FAIL single_tx_cnt: got %0d expected 1", tx_cnt);
    else n_pass++;
    g = 0; cs_ok = 1'b1;
    while (busy && g < 20) begin
      if (!bus.cs_n || bus.sclk) cs_ok = 1'b0;
      g++;
      @(negedge clk);
    end
    n_chk++;
    if (g !== CS_GAP) $display("FAIL gap_len: got %0d expected %0d", g, CS_GAP);
    else n_pass++;
    n_chk++;
    if (!cs_ok) $display("FAIL gap_cs_n: got cs_n low or sclk high in gap, expected cs_n=1 sclk=0");
    else n_pass++;
  endtask

`ifndef L2_TX_BURST_EN
  task automatic test_three_words;
    bit ok;
    int rd0, g, h;
    logic [15:0] base;
    rd0 = rd_total; base = tx_cnt;
    push_word(32'h0000_0001);
    push_word(32'hFFFF_FFFE);
    push_word(32'h5A5A_1234);
    for (int k = 0; k < 3; k++) begin
      wait_wd(FRAME + 50, ok);
      n_chk++;
      if (!ok) $display("FAIL three_timeout: got no word_done for word %0d", k);
      else n_pass++;
      if (k < 2) begin
        g = 0; h = 0;
        while (busy && g < 20) begin g++; h++; @(negedge clk); end
        while (bus.cs_n && h < 40) begin h++; @(negedge clk); end
        n_chk++;
        if (g !== CS_GAP) $display("FAIL three_gap: got %0d expected %0d", g, CS_GAP);
        else n_pass++;
        n_chk++;
        // Gap cycles plus one IDLE, one POP and one LOAD cycle before cs_n falls again.
        if (h !== CS_GAP + 3) $display("FAIL three_cs_high: got %0d expected %0d", h, CS_GAP + 3);
        else n_pass++;
      end
    end
    n_chk++;
    if (tx_cnt !== base + 16'd3) $display("FAIL three_tx_cnt: got %0d expected %0d", tx_cnt, base + 16'd3);
    else n_pass++;
    n_chk++;
    if (rd_total - rd0 !== 3) $display("FAIL three_pops: got %0d expected 3", rd_total - rd0);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({bus.fifo_empty, busy} !== 2'b10) $display("FAIL three_drained: got empty,busy=%b expected 10", {bus.fifo_empty, busy});
    else n_pass++;
  endtask
`else
  task automatic test_burst;
    int rd0, rises, wds, i;
    logic last;
    logic [15:0] base;
    rd0 = rd_total; base = tx_cnt; rises = 0; wds = 0;
    push_word(32'h8001_7FFE);
    push_word(32'h3C3C_C3C3);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.cs_n) break;
    end
    last = bus.sclk;
    for (i = 0; i < 2 * FRAME + 50; i++) begin
      @(negedge clk);
      if (bus.sclk && !last) rises++;
      if (word_done) wds++;
      last = bus.sclk;
      if (bus.cs_n) break;
    end
    n_chk++;
    if (rises !== 2 * DW) $display("FAIL burst_rises: got %0d expected %0d", rises, 2 * DW);
    else n_pass++;
    n_chk++;
    if (wds !== 2) $display("FAIL burst_word_done: got %0d expected 2", wds);
    else n_pass++;
    n_chk++;
    if (rd_total - rd0 !== 2) $display("FAIL burst_pops: got %0d expected 2", rd_total - rd0);
    else n_pass++;
    n_chk++;
    if (tx_cnt !== base + 16'd2) $display("FAIL burst_tx_cnt: got %0d expected %0d", tx_cnt, base + 16'd2);
    else n_pass++;
    repeat (CS_GAP + 2) @(negedge clk);
  endtask
`endif

  task automatic test_clr;
    int r;
    bit ok;
    logic [15:0] base;
    base = tx_cnt;
    push_word(32'hDEAD_BEEF);
    push_word(32'h1357_9BDF);
    wait_rises(10, r);
    n_chk++;
    if (r !== 10) $display("FAIL clr_rises: got %0d expected 10", r);
    else n_pass++;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_chk++;
    if ({bus.cs_n, bus.sclk, busy, bus.mosi, bus.fifo_rd} !== 5'b10000)
      $display("FAIL clr_outputs: got %b expected 10000", {bus.cs_n, bus.sclk, busy, bus.mosi, bus.fifo_rd});
    else n_pass++;
    n_chk++;
    if (tx_cnt !== base) $display("FAIL clr_tx_cnt: got %0d expected %0d", tx_cnt, base);
    else n_pass++;
    void'(exp_q.pop_front());
    wait_wd(FRAME + 50, ok);
    n_chk++;
    if (!ok || tx_cnt !== base + 16'd1)
      $display("FAIL clr_resume: got done=%b tx_cnt=%0d expected done=1 tx_cnt=%0d", ok, tx_cnt, base + 16'd1);
    else n_pass++;
    repeat (CS_GAP + 2) @(negedge clk);
  endtask

  task automatic test_rst;
    int r, rd0;
    bit ok;
    push_word(32'h0F0F_F0F0);
    wait_rises(5, r);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.fifo_rd, bus.sclk, bus.mosi, bus.cs_n, busy, word_done} !== 6'b000100)
      $display("FAIL async_rst_outputs: got %b expected 000100",
               {bus.fifo_rd, bus.sclk, bus.mosi, bus.cs_n, busy, word_done});
    else n_pass++;
    n_chk++;
    if (tx_cnt !== 16'd0) $display("FAIL async_rst_tx_cnt: got %0d expected 0", tx_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    rd0 = rd_total;
    push_word(32'hC001_D00D);
    wait_wd(FRAME + 50, ok);
    n_chk++;
    if (!ok || tx_cnt !== 16'd1 || rd_total - rd0 !== 1)
      $display("FAIL rst_resume: got done=%b tx_cnt=%0d pops=%0d expected 1 1 1", ok, tx_cnt, rd_total - rd0);
    else n_pass++;
    repeat (CS_GAP + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
`ifdef L2_TX_BURST_EN
    test_burst();
`else
    test_three_words();
`endif
    test_clr();
    test_rst();
    n_chk++;
    if (underflow !== 0) $display("FAIL underflow: got %0d empty pops expected 0", underflow);
    else n_pass++;
    n_chk++;
    if (exp_q.size() !== 0) $display("FAIL leftover_words: got %0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
